// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer for ram512: drives the RAM address, captures the
// combinational read word and offers it downstream over a valid/ready handshake.
module pc_fetch #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              running,
  output logic              wrapped,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   pc_inc;
  logic              handshake;

  // Extra top bit of the increment is the carry out of the last RAM address.
  assign pc_inc      = {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};
  assign handshake   = instr_valid & instr_ready;
  assign mem_address = pc;
  assign running     = (state != S_IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      wrapped     <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (jump_en) pc <= jump_addr;
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          instr       <= mem_out;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (handshake) begin
            retired     <= retired + 16'd1;
            instr_valid <= 1'b0;
            if (jump_en) begin
              pc <= jump_addr;
            end else begin
              pc <= pc_inc[ADDR_W-1:0];
              if (pc_inc[ADDR_W]) wrapped <= 1'b1;
            end
            state <= halt ? S_IDLE : S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a behavioural ram512 model feeds mem_out and
// hand-computed expectations are checked with immediate assertions.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  mem_address;
  logic [15:0] mem_out;
  logic [15:0] instr;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [8:0]  jump_addr;
  logic        halt;
  logic        running;
  logic        wrapped;
  logic [15:0] retired;

  logic [15:0] ram [512];

  int checks = 0;
  int passes = 0;

  pc_fetch #(.ADDR_W(9), .DATA_W(16), .RESET_ADDR(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mem_address (mem_address),
    .mem_out     (mem_out),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .running     (running),
    .wrapped     (wrapped),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Combinational RAM read, like ram512.
  assign mem_out = ram[mem_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'hA000 | 16'(i);
    ram[0] = 16'h1111;
    ram[1] = 16'h2222;
    ram[2] = 16'h3333;
    ram[3] = 16'h4444;

    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    jump_en = 1'b0; jump_addr = '0; halt = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_running", running, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_addr", mem_address, 0);
    check("rst_retired", retired, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_instr", instr, 0);

    // Sequential fetch from address 0
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("seq_running", running, 1);
    check("seq_fetch_valid", instr_valid, 0);
    tick();
    check("seq0_valid", instr_valid, 1);
    check("seq0_instr", instr, 16'h1111);
    check("seq0_pc", instr_pc, 0);
    tick();
    check("seq0_hs_valid", instr_valid, 0);
    check("seq0_hs_addr", mem_address, 1);
    check("seq0_hs_retired", retired, 1);
    tick();
    check("seq1_instr", instr, 16'h2222);
    check("seq1_pc", instr_pc, 1);
    tick(); tick();
    check("seq2_instr", instr, 16'h3333);
    check("seq2_pc", instr_pc, 2);
    check("seq2_retired", retired, 2);

    // Backpressure on pc=2
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_instr", instr, 16'h3333);
      check("bp_pc", instr_pc, 2);
      check("bp_addr", mem_address, 2);
      check("bp_valid", instr_valid, 1);
      check("bp_retired", retired, 2);
    end
    instr_ready = 1'b1;
    tick();
    check("bp_hs_retired", retired, 3);
    check("bp_hs_addr", mem_address, 3);
    check("bp_hs_valid", instr_valid, 0);
    tick();
    check("seq3_instr", instr, 16'h4444);
    check("seq3_pc", instr_pc, 3);
    check("seq3_retired", retired, 3);

    // Jump at handshake of pc=3
    jump_en = 1'b1; jump_addr = 9'h1F0;
    tick();
    jump_en = 1'b0; jump_addr = '0;
    check("jmp_addr", mem_address, 9'h1F0);
    check("jmp_retired", retired, 4);
    tick();
    check("jmp_pc", instr_pc, 9'h1F0);
    check("jmp_instr", instr, 16'hA1F0);
    check("jmp_wrapped", wrapped, 0);

    // Halt, then jump+start from IDLE
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h1_running", running, 0);
    check("h1_addr", mem_address, 9'h1F1);
    check("h1_retired", retired, 5);
    jump_en = 1'b1; jump_addr = 9'h100; start = 1'b1;
    tick();
    jump_en = 1'b0; start = 1'b0;
    check("ij_addr", mem_address, 9'h100);
    tick();
    check("ij_pc", instr_pc, 9'h100);
    check("ij_instr", instr, 16'hA100);

    // Wrap from the last address
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h2_retired", retired, 6);
    jump_en = 1'b1; jump_addr = 9'h1FF; start = 1'b1;
    tick();
    jump_en = 1'b0; start = 1'b0;
    tick();
    check("wr_pc_top", instr_pc, 9'h1FF);
    check("wr_instr_top", instr, 16'hA1FF);
    check("wr_before", wrapped, 0);
    tick();
    check("wr_addr", mem_address, 0);
    check("wr_flag", wrapped, 1);
    check("wr_retired", retired, 7);
    tick();
    check("wr_pc0", instr_pc, 0);
    check("wr_instr0", instr, 16'h1111);

    // Halt at handshake of pc=5, then resume
    repeat (10) tick();
    check("h3_pre_pc", instr_pc, 5);
    check("h3_pre_retired", retired, 12);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h3_running", running, 0);
    check("h3_addr", mem_address, 6);
    check("h3_retired", retired, 13);
    check("h3_valid", instr_valid, 0);
    tick(); tick();
    check("h3_idle_running", running, 0);
    check("h3_idle_addr", mem_address, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("res_pc", instr_pc, 6);
    check("res_instr", instr, 16'hA006);
    check("res_wrapped", wrapped, 1);

    // Asynchronous reset mid-WAIT
    instr_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("ar_valid", instr_valid, 0);
    check("ar_running", running, 0);
    check("ar_addr", mem_address, 0);
    check("ar_retired", retired, 0);
    check("ar_wrapped", wrapped, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_post_running", running, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
